id_ex_pipe: RTL
===============

# id_ex_pipe

Parametrised ID/EX pipeline register for the 16-bit MIPS pipeline. Replaces the pass-through ID/EX stage with a real registered stage: valid/ready handshake, 2-entry skid buffer for backpressure from EX, and synchronous flush for branch/hazard squash. Sits between the decode/register-file read logic and the EX stage. Forwarding and hazard detection units consume `outIdExOp1`/`outIdExOp2`.

## Interface
- `DATA_W`, 16: width of operand, zero-concat and sign-extended immediate fields
- `REG_AW`, 4: register-specifier width (`IdExOp1`/`IdExOp2`)
- `EX_W`, 2: EX control field width
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `flush` in 1: squash all held entries (synchronous)
- `in_valid` in 1: ID presents a valid instruction
- `in_ready` out 1: stage can accept this cycle
- `readDataOp1`, `readDataOp2` in DATA_W: register-file read data
- `concatZero`, `signExtImd` in DATA_W: immediates
- `IdExOp1`, `IdExOp2` in REG_AW: source register specifiers
- `wb`, `mem` in 1; `ex` in EX_W: control bits
- `out_valid` out 1: EX-side entry valid
- `out_ready` in 1: EX consumes the entry this cycle
- `outDataOp1`, `outDataOp2`, `outConcatZero`, `outSignExtImd` out DATA_W
- `outIdExOp1`, `outIdExOp2` out REG_AW
- `outWB`, `outMEM` out 1; `outEX` out EX_W

## Operation
- Payload P = all data, specifier and control inputs, packed in a fixed order; width `4*DATA_W + 2*REG_AW + 2 + EX_W`.
- Two entries: MAIN (drives outputs) and SKID. Each has a valid bit.
- `in_ready` = !skid_valid (registered state only, no combinational path from `out_ready`).
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Per edge, flush clear:
  - MAIN empty or popping, SKID full: SKID -> MAIN, SKID cleared; an accept that cycle loads SKID.
  - MAIN empty or popping, SKID empty: accept loads MAIN directly.
  - MAIN full, not popping, accept: payload loads SKID.
- `flush`=1: both valid bits cleared next edge. Any accept that cycle is dropped, even though `in_ready` was high. Flush overrides pop.
- Control gating: `outWB`, `outMEM`, `outEX` are forced to 0 whenever `out_valid`=0, so a bubble never writes back or touches memory. Data/specifier outputs show MAIN's payload regardless of valid.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.

## Timing
- Reset (async assert, sync-safe deassert by upstream): all payload regs 0, both valid 0. Outputs: `out_valid`=0, `in_ready`=1, all data/control outputs 0.
- Reset mid-operation discards both entries immediately.
- Latency: accept at edge N -> `out_valid` and payload visible after edge N (EX sees it cycle N+1).
- Throughput: 1 per cycle with `out_ready` held high.
- Single stall cycle (`out_ready`=0) absorbs one extra instruction in SKID. `in_ready` drops the cycle after SKID fills and rises the cycle after SKID drains.
- Flush and `in_valid` in the same cycle: next cycle `out_valid`=0, `in_ready`=1.

## Structure
- Shared `id_ex_pkg` (or common include) holds default widths, payload field offsets/packing order, and the bubble control value (all zeros). The hazard unit reuses them.
- One natural sub-module: `pipe_skid_reg`, a generic WIDTH-parameterised 2-entry valid/ready skid register with flush. `id_ex_pipe` packs/unpacks P around it and applies control gating.

## Test plan
- Reset then stream: feed ops with `readDataOp1`=0x0001..0x0005, `out_ready`=1 -> outputs 0x0001..0x0005 on consecutive cycles, one cycle after each accept. `in_ready` stays 1.
- Backpressure: stream A,B,C, drop `out_ready` for 2 cycles while A is held -> B enters SKID, `in_ready`=0, C held upstream. On release, output order is A,B,C with no loss or duplicate.
- Flush with full buffer: MAIN=A, SKID=B, `flush`=1 with `in_valid`=1 carrying C -> next cycle `out_valid`=0, `outWB`=`outMEM`=`outEX`=0, `in_ready`=1. C is never emitted.
- Bubble gating: accept `wb`=1, `mem`=1, `ex`=2'b11, then `in_valid`=0 -> after the pop, `out_valid`=0 and all control outputs are 0.
- Async reset mid-stall: assert `rst`=0 with both entries full, between clock edges -> outputs go to 0 and `out_valid`=0 immediately, `in_ready`=1.
- Parameter sweep: `DATA_W`=32, `REG_AW`=5, `EX_W`=4 -> rerun the first three scenarios with identical results. The field widths match the parameters.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared ID/EX payload definitions: default widths, packing offsets and bubble control value.
package id_ex_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 4;
  localparam int unsigned EX_W_DEF   = 2;

  localparam logic BUBBLE_WB  = 1'b0;
  localparam logic BUBBLE_MEM = 1'b0;

  // Packing order, LSB first: ex, mem, wb, op2, op1, signExtImd, concatZero, readDataOp2, readDataOp1.
  function automatic int unsigned payload_w(input int unsigned dw, input int unsigned aw,
                                            input int unsigned ew);
    return 4 * dw + 2 * aw + 2 + ew;
  endfunction

  function automatic int unsigned off_mem(input int unsigned ew);
    return ew;
  endfunction

  function automatic int unsigned off_wb(input int unsigned ew);
    return ew + 1;
  endfunction

  function automatic int unsigned off_op2(input int unsigned ew);
    return ew + 2;
  endfunction

  function automatic int unsigned off_op1(input int unsigned aw, input int unsigned ew);
    return ew + 2 + aw;
  endfunction

  function automatic int unsigned off_sx(input int unsigned aw, input int unsigned ew);
    return ew + 2 + 2 * aw;
  endfunction

  function automatic int unsigned off_cz(input int unsigned dw, input int unsigned aw,
                                         input int unsigned ew);
    return off_sx(aw, ew) + dw;
  endfunction

  function automatic int unsigned off_rd2(input int unsigned dw, input int unsigned aw,
                                          input int unsigned ew);
    return off_sx(aw, ew) + 2 * dw;
  endfunction

  function automatic int unsigned off_rd1(input int unsigned dw, input int unsigned aw,
                                          input int unsigned ew);
    return off_sx(aw, ew) + 3 * dw;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register with synchronous flush.
// in_ready depends only on registered state, breaking the combinational ready path.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             pop;

  assign accept      = in_valid_i & ~skid_vld_q;
  assign pop         = main_vld_q & out_ready_i;
  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || pop) begin
      if (skid_vld_q) begin
        // Older skid entry advances first to keep FIFO order.
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = in_data_i;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_data_i;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: packs decode outputs into a skid register and gates
// control outputs to a bubble whenever no valid entry is presented to EX.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned EX_W   = EX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] readDataOp1,
  input  logic [DATA_W-1:0] readDataOp2,
  input  logic [DATA_W-1:0] concatZero,
  input  logic [DATA_W-1:0] signExtImd,
  input  logic [REG_AW-1:0] IdExOp1,
  input  logic [REG_AW-1:0] IdExOp2,
  input  logic              wb,
  input  logic              mem,
  input  logic [EX_W-1:0]   ex,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] outDataOp1,
  output logic [DATA_W-1:0] outDataOp2,
  output logic [DATA_W-1:0] outConcatZero,
  output logic [DATA_W-1:0] outSignExtImd,
  output logic [REG_AW-1:0] outIdExOp1,
  output logic [REG_AW-1:0] outIdExOp2,
  output logic              outWB,
  output logic              outMEM,
  output logic [EX_W-1:0]   outEX
);

  localparam int unsigned PW      = payload_w(DATA_W, REG_AW, EX_W);
  localparam int unsigned O_MEM   = off_mem(EX_W);
  localparam int unsigned O_WB    = off_wb(EX_W);
  localparam int unsigned O_OP2   = off_op2(EX_W);
  localparam int unsigned O_OP1   = off_op1(REG_AW, EX_W);
  localparam int unsigned O_SX    = off_sx(REG_AW, EX_W);
  localparam int unsigned O_CZ    = off_cz(DATA_W, REG_AW, EX_W);
  localparam int unsigned O_RD2   = off_rd2(DATA_W, REG_AW, EX_W);
  localparam int unsigned O_RD1   = off_rd1(DATA_W, REG_AW, EX_W);

  logic [PW-1:0] in_p;
  logic [PW-1:0] out_p;

  always_comb begin
    in_p                   = '0;
    in_p[0 +: EX_W]        = ex;
    in_p[O_MEM]            = mem;
    in_p[O_WB]             = wb;
    in_p[O_OP2 +: REG_AW]  = IdExOp2;
    in_p[O_OP1 +: REG_AW]  = IdExOp1;
    in_p[O_SX  +: DATA_W]  = signExtImd;
    in_p[O_CZ  +: DATA_W]  = concatZero;
    in_p[O_RD2 +: DATA_W]  = readDataOp2;
    in_p[O_RD1 +: DATA_W]  = readDataOp1;
  end

  pipe_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_p),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_p)
  );

  assign outDataOp1    = out_p[O_RD1 +: DATA_W];
  assign outDataOp2    = out_p[O_RD2 +: DATA_W];
  assign outConcatZero = out_p[O_CZ  +: DATA_W];
  assign outSignExtImd = out_p[O_SX  +: DATA_W];
  assign outIdExOp1    = out_p[O_OP1 +: REG_AW];
  assign outIdExOp2    = out_p[O_OP2 +: REG_AW];

  // A bubble must never write back, touch memory or drive EX control.
  assign outWB  = out_valid ? out_p[O_WB]       : BUBBLE_WB;
  assign outMEM = out_valid ? out_p[O_MEM]      : BUBBLE_MEM;
  assign outEX  = out_valid ? out_p[0 +: EX_W]  : '0;

endmodule
